// File: rtl/shared_alu_sched.sv
// shared_alu_sched: N requesters share one small ALU through a round-robin arbiter
// and a three-state FSM (IDLE -> EXEC -> DONE). The winner's operands are latched
// on the grant edge, the result is registered one cycle later with a done pulse,
// and the FSM then spends one cycle in DONE before it can arbitrate again.
//
// Ports:
//   clk     clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   req     per-requester request level (bit i = requester i)
//   op_a    operand A, requester i at [i*W +: W]
//   op_b    operand B, requester i at [i*W +: W]
//   op_sel  operation select, requester i at [2*i +: 2]
//           (00: A&~B, 01: A<<B, 10: A>>B, 11: A^B)
//   gnt     one-hot grant pulse, marks operand capture
//   done    one-hot completion pulse to the served requester
//   result  result of the most recent completed operation
//   busy    high while the FSM is not in IDLE
module shared_alu_sched #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   op_a,
    input  logic [N*W-1:0]   op_b,
    input  logic [2*N-1:0]   op_sel,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [W-1:0]     result,
    output logic             busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    sel_q;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic [W-1:0]  alu_res;

    logic          capture;
    logic [N-1:0]  gnt_n;
    logic [N-1:0]  done_n;
    logic [W-1:0]  result_n;
    logic          busy_n;

    // Round-robin pick: scan from ptr+1 upward (wrapping), first set req wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // ALU on the latched operands; shift amount uses only the low clog2(W) bits of B.
    always_comb begin
        case (sel_q)
            2'b00:   alu_res = a_q & ~b_q;
            2'b01:   alu_res = a_q << b_q[SW-1:0];
            2'b10:   alu_res = a_q >> b_q[SW-1:0];
            default: alu_res = a_q ^ b_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_n  = state;
        capture  = 1'b0;
        gnt_n    = '0;
        done_n   = '0;
        result_n = result;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = EXEC;
                    capture = 1'b1;
                    gnt_n   = N'(1) << pick_idx;
                end
            end
            EXEC: begin
                state_n  = DONE;
                done_n   = N'(1) << win;
                result_n = alu_res;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
        end else begin
            gnt    <= gnt_n;
            done   <= done_n;
            result <= result_n;
            busy   <= busy_n;
        end
    end

    // Operand capture and round-robin pointer, both only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= IW'(N - 1);
            win   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
        end else if (capture) begin
            ptr   <= pick_idx;
            win   <= pick_idx;
            a_q   <= op_a[32'(pick_idx) * W +: W];
            b_q   <= op_b[32'(pick_idx) * W +: W];
            sel_q <= op_sel[32'(pick_idx) * 2 +: 2];
        end
    end

endmodule

// File: tb/tb_shared_alu_sched.sv
// Scoreboard bench for shared_alu_sched (N=4, W=8). Stimulus pushes expected grants
// and completions into queues; a monitor pops and compares on every gnt/done pulse.
module tb_shared_alu_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [2*N-1:0] op_sel;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           busy;

    typedef struct packed {
        logic [N-1:0] d;
        logic [W-1:0] r;
    } done_t;

    logic [N-1:0] gq[$];
    done_t        dq[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shared_alu_sched #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_sel (op_sel),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare every presented grant / completion against the scoreboard.
    always @(posedge clk) begin
        logic [N-1:0] eg;
        done_t        ed;
        #1;
        if ((gnt & done) != '0) check("gnt_done_overlap", 32'(gnt & done), 32'h0);
        if (gnt != '0) begin
            if (gq.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'h0);
            end else begin
                eg = gq.pop_front();
                check("gnt", 32'(gnt), 32'(eg));
            end
        end
        if (done != '0) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                ed = dq.pop_front();
                check("done", 32'(done), 32'(ed.d));
                check("result", 32'(result), 32'(ed.r));
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        op_a[i*8 +: 8]   = a;
        op_b[i*8 +: 8]   = b;
        op_sel[i*2 +: 2] = s;
    endtask

    task automatic expect_op(input int i, input logic [7:0] r);
        done_t e;
        gq.push_back(N'(1) << i);
        e.d = N'(1) << i;
        e.r = r;
        dq.push_back(e);
    endtask

    // One-shot request from requester i; req is dropped right after the grant edge.
    task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] s, input logic [7:0] r);
        set_op(i, a, b, s);
        expect_op(i, r);
        req = N'(1) << i;
        @(negedge clk);              // after E0
        req = '0;
        check("busy_exec", 32'(busy), 32'h1);
        @(negedge clk);              // after E1
        @(negedge clk);              // after E2
        check("busy_idle", 32'(busy), 32'h0);
        @(negedge clk);
        check("result_hold", 32'(result), 32'(r));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for the next grant pulse; returns the cycle it appeared.
    task automatic wait_gnt(output int at, output bit ok);
        int n;
        ok = 1'b0;
        at = 0;
        n  = 0;
        while (!ok && n < 12) begin
            @(posedge clk);
            #1;
            if (gnt != '0) begin
                ok = 1'b1;
                at = cyc;
            end
            n++;
        end
        if (!ok) check("gnt_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int t_prev;
        int t_now;
        bit ok;

        rst_n  = 1'b0;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        op_sel = '0;
        @(negedge clk);
        do_reset();
        @(negedge clk);

        // Single request, A & ~B: 0xF0 & ~0x3C = 0xC0
        single(0, 8'hF0, 8'h3C, 2'b00, 8'hC0);

        // Requester 2 operations
        single(2, 8'h81, 8'h03, 2'b01, 8'h08);   // 0x81 << 3 = 0x408 -> 0x08
        single(2, 8'h81, 8'h0B, 2'b10, 8'h10);   // B[2:0]=3, 0x81 >> 3 = 0x10
        single(2, 8'hAA, 8'hFF, 2'b11, 8'h55);

        // Round-robin fairness from a fresh pointer: 0,1,2,3,0 every 3 cycles
        do_reset();
        set_op(0, 8'h0F, 8'hF0, 2'b11);          // 0xFF
        set_op(1, 8'hFF, 8'h0F, 2'b00);          // 0xF0
        set_op(2, 8'h01, 8'h07, 2'b01);          // 0x80
        set_op(3, 8'h80, 8'h07, 2'b10);          // 0x01
        expect_op(0, 8'hFF);
        expect_op(1, 8'hF0);
        expect_op(2, 8'h80);
        expect_op(3, 8'h01);
        expect_op(0, 8'hFF);
        req = 4'b1111;
        wait_gnt(t_prev, ok);
        for (int g = 1; g < 5; g++) begin
            wait_gnt(t_now, ok);
            if (ok) check("gnt_spacing", 32'(t_now - t_prev), 32'd3);
            t_prev = t_now;
        end
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Operand stability: A changes after grant, result uses the latched value
        set_op(0, 8'h0F, 8'h00, 2'b11);
        expect_op(0, 8'h0F);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        set_op(0, 8'hFF, 8'h00, 2'b11);
        repeat (3) @(negedge clk);
        check("stable_result", 32'(result), 32'h0F);

        // Reset while in EXEC: grant only, no completion
        set_op(0, 8'h12, 8'h00, 2'b11);
        gq.push_back(4'b0001);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        check("pre_rst_busy", 32'(busy), 32'h1);
        do_reset();
        set_op(1, 8'h3C, 8'h0F, 2'b00);          // 0x30
        expect_op(1, 8'h30);
        req = 4'b0010;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (3) @(negedge clk);

        // Request drop: req[3] falls after grant, completion still delivered; next goes to 0
        set_op(3, 8'h12, 8'h34, 2'b11);          // 0x26
        set_op(0, 8'h55, 8'h0F, 2'b00);          // 0x50
        set_op(2, 8'h01, 8'h01, 2'b01);
        expect_op(3, 8'h26);
        expect_op(0, 8'h50);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0101;
        repeat (3) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        check("gq_empty", 32'(gq.size()), 32'h0);
        check("dq_empty", 32'(dq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
